// File: rtl/traffic_phase_scheduler.sv
// Timed, actuated phase scheduler for a two-approach intersection with a
// pedestrian crossing. One approach is green at a time; min/max green, fixed
// yellow, all-red clearance and a walk phase are all counted in tick strobes.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 5,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       north_s,
    input  logic       east_s,
    input  logic       ped_req,
    output logic [2:0] north_l,
    output logic [2:0] east_l,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        N_GRN  = 3'd1,
        N_YEL  = 3'd2,
        E_GRN  = 3'd3,
        E_YEL  = 3'd4,
        ALLRED = 3'd5,
        WALK   = 3'd6
    } state_e;

    localparam logic LAST_NORTH = 1'b0;
    localparam logic LAST_EAST  = 1'b1;

    // Terminal timer values: a timed state exits on the tick where timer==DUR-1.
    localparam logic [CNT_W-1:0] G_MIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1  = CNT_W'(WALK_T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;
    logic             last_served_q, last_served_d;

    state_e           arb_state;
    logic             arb_last;

    // Arbitration: pedestrian first, then fair alternation, then single requester.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        arb_state = IDLE;
        arb_last  = last_served_q;
        if (ped_pend_q) begin
            arb_state = WALK;
        end else if (north_s && east_s) begin
            if (last_served_q == LAST_EAST) begin
                arb_state = N_GRN;
                arb_last  = LAST_NORTH;
            end else begin
                arb_state = E_GRN;
                arb_last  = LAST_EAST;
            end
        end else if (north_s) begin
            arb_state = N_GRN;
            arb_last  = LAST_NORTH;
        end else if (east_s) begin
            arb_state = E_GRN;
            arb_last  = LAST_EAST;
        end
    end

    // Next-state and timer: timers advance only on tick; IDLE arbitrates every clk.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (arb_state != IDLE) begin
                    state_d       = arb_state;
                    timer_d       = '0;
                    last_served_d = arb_last;
                end
            end
            N_GRN: begin
                if (tick) begin
                    if ((east_s || ped_pend_q) &&
                        ((timer_q >= G_MIN_M1 && !north_s) || timer_q == G_MAX_M1)) begin
                        state_d = N_YEL;
                        timer_d = '0;
                    end else if (timer_q != G_MAX_M1) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            E_GRN: begin
                if (tick) begin
                    if ((north_s || ped_pend_q) &&
                        ((timer_q >= G_MIN_M1 && !east_s) || timer_q == G_MAX_M1)) begin
                        state_d = E_YEL;
                        timer_d = '0;
                    end else if (timer_q != G_MAX_M1) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            N_YEL, E_YEL: begin
                if (tick) begin
                    if (timer_q == YEL_M1) begin
                        state_d = ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ALLRED: begin
                if (tick) begin
                    if (timer_q == AR_M1) begin
                        state_d       = arb_state;
                        timer_d       = '0;
                        last_served_d = arb_last;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            WALK: begin
                if (tick) begin
                    if (timer_q == WALK_M1) begin
                        state_d = ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Pedestrian latch: entering WALK clears it and beats a same-cycle set.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_d == WALK && state_q != WALK) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && state_q != WALK) begin
            ped_pend_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            ped_pend_q    <= 1'b0;
            last_served_q <= LAST_EAST;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pend_q    <= ped_pend_d;
            last_served_q <= last_served_d;
        end
    end

    // Moore lamp decode straight from the state register.
    always_comb begin
        north_l = 3'b100;
        east_l  = 3'b100;
        walk    = 1'b0;
        phase   = state_q;
        case (state_q)
            N_GRN:   north_l = 3'b001;
            N_YEL:   north_l = 3'b010;
            E_GRN:   east_l  = 3'b001;
            E_YEL:   east_l  = 3'b010;
            WALK:    walk    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: a cycle reference model
// pushes expected outputs into a queue as stimulus is applied, and each result
// is popped and compared after the clock edge. Directed phase-length checks
// use constants taken from the bench timing parameters.
module tb_traffic_phase_scheduler;

    localparam int CNT_W     = 4;
    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 5;

    localparam logic [9:0] OUT_IDLE = {3'd0, 3'b100, 3'b100, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b1;
    logic       north_s = 1'b0;
    logic       east_s = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] north_l, east_l, phase;
    logic       walk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_state = 0;
    int m_timer = 0;
    int m_pend  = 0;
    int m_last  = 1;   // 0 north, 1 east

    logic [9:0] exp_q[$];

    traffic_phase_scheduler #(
        .CNT_W(CNT_W), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .north_s(north_s), .east_s(east_s),
        .ped_req(ped_req), .north_l(north_l), .east_l(east_l), .walk(walk),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] out_of(input int st);
        case (st)
            1:       return {3'd1, 3'b001, 3'b100, 1'b0};
            2:       return {3'd2, 3'b010, 3'b100, 1'b0};
            3:       return {3'd3, 3'b100, 3'b001, 1'b0};
            4:       return {3'd4, 3'b100, 3'b010, 1'b0};
            5:       return {3'd5, 3'b100, 3'b100, 1'b0};
            6:       return {3'd6, 3'b100, 3'b100, 1'b1};
            default: return OUT_IDLE;
        endcase
    endfunction

    function automatic logic [9:0] dut_out();
        return {phase, north_l, east_l, walk};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_timer = 0;
        m_pend  = 0;
        m_last  = 1;
    endtask

    // Advance the model one clk from the current inputs, push its prediction,
    // then clock the DUT and compare.
    task automatic step();
        int a_st, a_last, ns, nt, nl, np, mine, other;
        a_last = m_last;
        if (m_pend != 0)               a_st = 6;
        else if (north_s && east_s) begin
            a_st   = (m_last == 1) ? 1 : 3;
            a_last = (m_last == 1) ? 0 : 1;
        end
        else if (north_s) begin a_st = 1; a_last = 0; end
        else if (east_s)  begin a_st = 3; a_last = 1; end
        else                           a_st = 0;

        ns = m_state; nt = m_timer; nl = m_last;
        case (m_state)
            0: if (a_st != 0) begin ns = a_st; nt = 0; nl = a_last; end
            1, 3: if (tick) begin
                mine  = (m_state == 1) ? int'(north_s) : int'(east_s);
                other = (m_state == 1) ? int'(east_s)  : int'(north_s);
                if ((other != 0 || m_pend != 0) &&
                    ((m_timer >= GREEN_MIN - 1 && mine == 0) || m_timer == GREEN_MAX - 1)) begin
                    ns = m_state + 1; nt = 0;
                end else if (m_timer < GREEN_MAX - 1) nt = m_timer + 1;
            end
            2, 4: if (tick) begin
                if (m_timer == YELLOW_T - 1) begin ns = 5; nt = 0; end
                else nt = m_timer + 1;
            end
            5: if (tick) begin
                if (m_timer == ALLRED_T - 1) begin ns = a_st; nt = 0; nl = a_last; end
                else nt = m_timer + 1;
            end
            6: if (tick) begin
                if (m_timer == WALK_T - 1) begin ns = 5; nt = 0; end
                else nt = m_timer + 1;
            end
            default: ;
        endcase
        np = m_pend;
        if (ns == 6 && m_state != 6)          np = 0;
        else if (ped_req && m_state != 6)     np = 1;

        m_state = ns; m_timer = nt; m_last = nl; m_pend = np;
        exp_q.push_back(out_of(m_state));

        @(posedge clk);
        #1;
        check("cycle", dut_out(), exp_q.pop_front());
    endtask

    // Count consecutive clks spent in a phase (bounded).
    task automatic measure(input int code, output int len);
        len = 0;
        while (phase == 3'(code) && len < 60) begin
            len++;
            step();
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #1 rst = 1'b0;
        #1 check(tag, dut_out(), OUT_IDLE);
        model_reset();
        north_s = 1'b0; east_s = 1'b0; ped_req = 1'b0; tick = 1'b1;
        #1 rst = 1'b1;
    endtask

    initial begin
        int len;
        // Power-on reset
        repeat (2) @(posedge clk);
        #1 check("rst_hold", dut_out(), OUT_IDLE);
        #2 rst = 1'b1;
        model_reset();

        // 1. Idle with no demand
        repeat (20) step();
        check("s1_idle", phase, 0);

        // 2. Both approaches: north first, then alternation
        north_s = 1'b1; east_s = 1'b1;
        step();
        check("s2_first", phase, 1);
        measure(1, len); check("s2_ngrn_len", len, GREEN_MAX);
        measure(2, len); check("s2_nyel_len", len, YELLOW_T);
        measure(5, len); check("s2_ar_len", len, ALLRED_T);
        check("s2_to_east", phase, 3);
        measure(3, len); check("s2_egrn_len", len, GREEN_MAX);
        measure(4, len); check("s2_eyel_len", len, YELLOW_T);
        measure(5, len); check("s2_ar2_len", len, ALLRED_T);
        check("s2_to_north", phase, 1);
        measure(1, len); check("s2_ngrn2_len", len, GREEN_MAX);
        check("s2_in_nyel", phase, 2);
        // 1b. Async reset mid-yellow
        async_reset("s1_async_rst");
        step();
        check("s1_after_rst", phase, 0);

        // 3. North alone holds; east request gaps it out
        north_s = 1'b1;
        step();
        check("s3_ngrn", phase, 1);
        repeat (30) step();
        check("s3_hold", phase, 1);
        north_s = 1'b0; east_s = 1'b1;
        step();
        check("s3_gap_out", phase, 2);
        measure(2, len); check("s3_nyel_len", len, YELLOW_T);
        measure(5, len); check("s3_ar_len", len, ALLRED_T);
        check("s3_egrn", phase, 3);

        // 4. Pedestrian during east green with east held
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        measure(3, len); check("s4_egrn_len", len + 1, GREEN_MAX);
        measure(4, len); check("s4_eyel_len", len, YELLOW_T);
        measure(5, len); check("s4_ar_len", len, ALLRED_T);
        check("s4_walk", phase, 6);
        check("s4_walk_lamp", walk, 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        measure(6, len); check("s4_walk_len", len + 1, WALK_T);
        measure(5, len); check("s4_ar2_len", len, ALLRED_T);
        check("s4_no_repeat_walk", phase, 3);

        // 5. Tick freeze during north green with east waiting
        async_reset("s5_rst");
        north_s = 1'b1;
        step();
        check("s5_ngrn", phase, 1);
        north_s = 1'b0; east_s = 1'b1; tick = 1'b0;
        repeat (10) step();
        check("s5_frozen", phase, 1);
        tick = 1'b1;
        measure(1, len); check("s5_ngrn_len", len, GREEN_MIN);
        measure(2, len); check("s5_nyel_len", len, YELLOW_T);
        measure(5, len); check("s5_ar_len", len, ALLRED_T);
        check("s5_egrn", phase, 3);

        // 6. North re-granted when east has gone away
        async_reset("s6_rst");
        north_s = 1'b1; east_s = 1'b1;
        step();
        measure(1, len); check("s6_ngrn_len", len, GREEN_MAX);
        east_s = 1'b0;
        measure(2, len); check("s6_nyel_len", len, YELLOW_T);
        measure(5, len); check("s6_ar_len", len, ALLRED_T);
        check("s6_regrant", phase, 1);

        // Random traffic against the reference model
        async_reset("rnd_rst");
        for (int i = 0; i < 600; i++) begin
            tick    = ($urandom_range(0, 3) != 0);
            north_s = ($urandom_range(0, 2) != 0);
            east_s  = ($urandom_range(0, 2) == 0);
            ped_req = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
